// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing helpers for the iterative divider.
package div_pkg;

  localparam int DIV_M = 5;
  localparam int DIV_N = 4;
  localparam int DIV_W = DIV_M + DIV_N;

  // Controller states.
  // state   | meaning
  // ST_IDLE | ready for operands, outputs hold last result
  // ST_CALC | one restoring step per clock, W steps total
  // ST_FIX  | apply signs, register the result, pulse valid
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  // Step counter width: must hold W-1.
  function automatic int div_cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  localparam int DIV_CNT_W = div_cnt_w(DIV_W);

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
// Shifts the next dividend bit into the partial remainder and subtracts |b|
// when that does not go negative; the quotient bit says whether it did.
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N:0]   i_pr,
  input  logic         i_bit,
  input  logic [N-1:0] i_absb,
  output logic [N:0]   o_pr,
  output logic         o_qbit
);

  localparam int SW = N + 2;
  localparam int PW = N + 1;

  logic [SW-1:0] w_shift;
  logic [SW-1:0] w_divisor;
  logic [SW-1:0] w_diff;

  // The extra top bit keeps the shifted value exact even though the
  // partial remainder itself never exceeds |b|-1.
  assign w_shift   = {i_pr, i_bit};
  assign w_divisor = SW'(i_absb);
  assign w_diff    = w_shift - w_divisor;
  assign o_qbit    = (w_shift >= w_divisor);
  assign o_pr      = o_qbit ? PW'(w_diff) : PW'(w_shift);

endmodule

// File: rtl/div_seq.sv
// div_seq: iterative signed truncating divider, (M+N)-bit dividend by N-bit
// divisor, one restoring step per clock, latency W+1, throughput 1 per W+2.
// Optional macro DIV_SEQ_ERR_EN adds the div_out_err flag (divide-by-zero or
// -2^(W-1)/-1 overflow). Quotient/remainder values are identical either way.
module div_seq
  import div_pkg::*;
#(
  parameter int M = DIV_M,
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           div_in_valid,
  output logic           div_in_ready,
  input  logic [M+N-1:0] div_in_a,
  input  logic [N-1:0]   div_in_b,
  output logic           div_out_valid,
  output logic [M+N-1:0] div_out_quot,
  output logic [N-1:0]   div_out_rem
`ifdef DIV_SEQ_ERR_EN
  ,
  output logic           div_out_err
`endif
);

  localparam int W  = M + N;
  localparam int CW = div_cnt_w(W);

  div_state_e    r_state;
  div_state_e    w_state_nxt;
  logic          w_accept;
  logic          w_calc;
  logic          w_fix;

  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_dvd;
  logic [N-1:0]  r_absb;
  logic [N:0]    r_pr;
  logic          r_sign_q;
  logic          r_sign_r;

  logic [N:0]    w_pr_nxt;
  logic          w_qbit;
  logic [W-1:0]  w_abs_a;
  logic [N-1:0]  w_abs_b;
  logic          w_div0;
  logic [N-1:0]  w_rem_mag;
  logic [W-1:0]  w_quot;
  logic [N-1:0]  w_rem;

  logic          r_out_valid;
  logic [W-1:0]  r_out_quot;
  logic [N-1:0]  r_out_rem;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: CALC runs until the down-counter hits zero.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (div_in_valid) w_state_nxt = ST_CALC;
      ST_CALC: if (r_cnt == '0) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded controls.
  always_comb begin
    div_in_ready = 1'b0;
    w_calc       = 1'b0;
    w_fix        = 1'b0;
    case (r_state)
      ST_IDLE: div_in_ready = 1'b1;
      ST_CALC: w_calc       = 1'b1;
      ST_FIX:  w_fix        = 1'b1;
      default: ;
    endcase
  end

  assign w_accept = div_in_valid & div_in_ready;

  // -2^(W-1) negates to itself, which is the correct unsigned magnitude.
  assign w_abs_a = div_in_a[W-1] ? -div_in_a : div_in_a;
  assign w_abs_b = div_in_b[N-1] ? -div_in_b : div_in_b;

  div_step #(.N(N)) u_step (
    .i_pr   (r_pr),
    .i_bit  (r_dvd[W-1]),
    .i_absb (r_absb),
    .o_pr   (w_pr_nxt),
    .o_qbit (w_qbit)
  );

  // Operand capture on accept, then shift quotient bits into the dividend register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_absb   <= '0;
      r_pr     <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= CW'(W - 1);
      r_dvd    <= w_abs_a;
      r_absb   <= w_abs_b;
      r_pr     <= '0;
      r_sign_q <= div_in_a[W-1] ^ div_in_b[N-1];
      r_sign_r <= div_in_a[W-1];
    end else if (w_calc) begin
      r_cnt    <= r_cnt - CW'(1);
      r_dvd    <= {r_dvd[W-2:0], w_qbit};
      r_pr     <= w_pr_nxt;
    end
  end

  // A zero magnitude divisor can only come from b==0, so it needs no extra flag.
  assign w_div0    = (r_absb == '0);
  assign w_rem_mag = N'(r_pr);
  assign w_quot    = w_div0 ? '0 : (r_sign_q ? -r_dvd : r_dvd);
  assign w_rem     = w_div0 ? '0 : (r_sign_r ? -w_rem_mag : w_rem_mag);

`ifdef DIV_SEQ_ERR_EN
  logic r_zero;
  logic r_ovf;
  logic r_out_err;

  // Classify error cases from the raw operands at accept time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_zero <= (div_in_b == '0);
      r_ovf  <= (div_in_a == {1'b1, {(W-1){1'b0}}}) && (div_in_b == '1);
    end
  end
`endif

  // Result registers: updated only in FIX, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_quot  <= '0;
      r_out_rem   <= '0;
`ifdef DIV_SEQ_ERR_EN
      r_out_err   <= 1'b0;
`endif
    end else begin
      r_out_valid <= w_fix;
      if (w_fix) begin
        r_out_quot <= w_quot;
        r_out_rem  <= w_rem;
`ifdef DIV_SEQ_ERR_EN
        r_out_err  <= r_zero | r_ovf;
`endif
      end
    end
  end

  assign div_out_valid = r_out_valid;
  assign div_out_quot  = r_out_quot;
  assign div_out_rem   = r_out_rem;
`ifdef DIV_SEQ_ERR_EN
  assign div_out_err   = r_out_err;
`endif

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and random checks of div_seq with a result scoreboard.
// Honours DIV_SEQ_ERR_EN to connect and check div_out_err.
module tb_div_seq;

  localparam int M = 5;
  localparam int N = 4;
  localparam int W = M + N;

  typedef struct {
    logic [W-1:0] q;
    logic [N-1:0] r;
    logic         e;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         div_in_valid = 1'b0;
  logic [W-1:0] div_in_a = '0;
  logic [N-1:0] div_in_b = '0;
  logic         div_in_ready;
  logic         div_out_valid;
  logic [W-1:0] div_out_quot;
  logic [N-1:0] div_out_rem;
`ifdef DIV_SEQ_ERR_EN
  logic         div_out_err;
`endif

  exp_t sb[$];
  exp_t p_exp;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_res = 0;
  bit   in_stream = 1'b0;
  int   last_acc = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_seq #(.M(M), .N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .div_in_valid  (div_in_valid),
    .div_in_ready  (div_in_ready),
    .div_in_a      (div_in_a),
    .div_in_b      (div_in_b),
    .div_out_valid (div_out_valid),
    .div_out_quot  (div_out_quot),
    .div_out_rem   (div_out_rem)
`ifdef DIV_SEQ_ERR_EN
    ,
    .div_out_err   (div_out_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input int q, input int r, input bit e);
    exp_t x;
    x.q = W'(q);
    x.r = N'(r);
    x.e = e;
    x.acc = 0;
    return x;
  endfunction

  // Truncating reference built on integer division.
  function automatic exp_t model(input int a, input int b);
    exp_t x;
    x.acc = 0;
    if (b == 0) begin
      x.q = '0;
      x.r = '0;
      x.e = 1'b1;
    end else begin
      x.q = W'(a / b);
      x.r = N'(a % b);
      x.e = (a == -(2 ** (W - 1))) && (b == -1);
    end
    return x;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (div_out_valid === 1'b1) begin
        n_vec++;
        assert (sb.size() > 0) else begin
          n_err++;
          $error("FAIL spurious_valid: pending %0d, required >0", sb.size());
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          n_res++;
          chk("quot", 32'(div_out_quot), 32'(e.q));
          chk("rem", 32'(div_out_rem), 32'(e.r));
          chk("latency", 32'(cyc - e.acc), 32'd10);
`ifdef DIV_SEQ_ERR_EN
          chk("err", 32'(div_out_err), 32'(e.e));
`endif
        end
      end
      if (div_in_valid === 1'b1 && div_in_ready === 1'b1 && rst === 1'b0) begin
        e = p_exp;
        e.acc = cyc + 1;
        if (in_stream && last_acc >= 0) chk("stream_interval", 32'(e.acc - last_acc), 32'd11);
        last_acc = e.acc;
        sb.push_back(e);
        n_acc++;
      end
    end
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input int a, input int b, input exp_t x);
    int t;
    t = 0;
    div_in_a = W'(a);
    div_in_b = N'(b);
    p_exp = x;
    div_in_valid = 1'b1;
    @(negedge clk);
    while (div_in_ready !== 1'b1 && t < 50) begin
      t++;
      @(negedge clk);
    end
    chk("ready_timeout", 32'(div_in_ready), 32'd1);
    @(posedge clk);
    #1 div_in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int a;
    int b;
    int acc0;
    int res0;
    int nv;

    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(div_in_ready), 32'd1);
    chk("rst_valid", 32'(div_out_valid), 32'd0);
    chk("rst_quot", 32'(div_out_quot), 32'd0);
    chk("rst_rem", 32'(div_out_rem), 32'd0);
`ifdef DIV_SEQ_ERR_EN
    chk("rst_err", 32'(div_out_err), 32'd0);
`endif
    @(posedge clk);
    #1;

    send(36, 3, mk(12, 0, 1'b0));
    wait_idle();

    send(-36, 3, mk(-12, 0, 1'b0));
    send(37, -4, mk(-9, 1, 1'b0));
    send(-37, -4, mk(9, -1, 1'b0));
    send(7, -8, mk(0, 7, 1'b0));
    wait_idle();

    send(105, 0, mk(0, 0, 1'b1));
    send(-256, -1, mk(-256, 0, 1'b1));
    wait_idle();

    // Valid held high with operands changing every cycle.
    in_stream = 1'b1;
    last_acc = -1;
    acc0 = n_acc;
    res0 = n_res;
    div_in_valid = 1'b1;
    for (int i = 0; i < 55; i++) begin
      a = $urandom_range(0, 511);
      if (a >= 256) a -= 512;
      b = $urandom_range(0, 15);
      if (b >= 8) b -= 16;
      div_in_a = W'(a);
      div_in_b = N'(b);
      p_exp = model(a, b);
      @(posedge clk);
      #1;
    end
    div_in_valid = 1'b0;
    in_stream = 1'b0;
    chk("stream_accepts", 32'(n_acc - acc0), 32'd5);
    wait_idle();
    chk("stream_results", 32'(n_res - res0), 32'd5);

    // Abort in mid-calculation.
    send(36, 3, mk(12, 0, 1'b0));
    wait_idle();
    send(100, 7, mk(14, 2, 1'b0));
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_valid", 32'(div_out_valid), 32'd0);
    chk("abort_quot", 32'(div_out_quot), 32'd0);
    chk("abort_rem", 32'(div_out_rem), 32'd0);
    chk("abort_ready", 32'(div_in_ready), 32'd1);
`ifdef DIV_SEQ_ERR_EN
    chk("abort_err", 32'(div_out_err), 32'd0);
`endif
    nv = 0;
    repeat (15) begin
      @(negedge clk);
      if (div_out_valid === 1'b1) nv++;
    end
    chk("abort_no_valid", 32'(nv), 32'd0);
    @(posedge clk);
    #1;
    send(-100, 7, mk(-14, -2, 1'b0));
    wait_idle();

    // Random sweep against the integer reference.
    for (int i = 0; i < 2000; i++) begin
      a = $urandom_range(0, 511);
      if (a >= 256) a -= 512;
      b = $urandom_range(0, 15);
      if (b >= 8) b -= 16;
      send(a, b, model(a, b));
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
